rv64g_l2_dir_update: RTL and testbench

RV64G_L2_DIR_UPDATE -- requirements
Module: rv64g_l2_dir_update

---
 rtl/rv64g_l2_dir_update_pkg.sv | 21 ++
 rtl/rv64g_l2_dir_next.sv | 98 +++++++++
 rtl/rv64g_l2_dir_update.sv | 220 ++++++++++++++++++++++
 tb/tb_rv64g_l2_dir_update.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64g_l2_dir_update_pkg.sv
// Shared encodings for the L2 directory update slice: request opcodes and controller states.
// Imported by rv64g_l2_dir_next and rv64g_l2_dir_update.
package rv64g_l2_pkg;

    typedef enum logic [1:0] {
        OP_ACQ_S   = 2'd0,
        OP_ACQ_E   = 2'd1,
        OP_RELEASE = 2'd2,
        OP_EVICT   = 2'd3
    } dir_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } dir_state_e;

    localparam int STAT_W = 32;

endpackage

// File: rtl/rv64g_l2_dir_next.sv
// Combinational next-state and probe computation for one directory entry.
// An entry read with valid=0 is treated as all-zero before the opcode is applied.
module rv64g_l2_dir_next
    import rv64g_l2_pkg::*;
#(
    parameter  int CORES = 4,
    localparam int CW    = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  dir_op_e           i_op,
    input  logic [CW-1:0]     i_core,
    input  logic              i_valid,
    input  logic              i_owner_valid,
    input  logic              i_dirty,
    input  logic [CORES-1:0]  i_sharers,
    input  logic [CW-1:0]     i_owner_id,
    output logic              o_valid,
    output logic              o_owner_valid,
    output logic              o_dirty,
    output logic [CORES-1:0]  o_sharers,
    output logic [CW-1:0]     o_owner_id,
    output logic [CORES-1:0]  o_probe
);

    logic             w_ov;
    logic             w_d;
    logic [CORES-1:0] w_sh;
    logic [CW-1:0]    w_oid;
    logic [CORES-1:0] w_core_bit;
    logic [CORES-1:0] w_owner_bit;
    logic [CORES-1:0] w_owner_mask;
    logic             w_nov;
    logic             w_nd;
    logic [CORES-1:0] w_nsh;

    always_comb begin
        w_ov  = i_valid & i_owner_valid;
        w_d   = i_valid & i_dirty;
        w_sh  = i_valid ? i_sharers : '0;
        w_oid = i_valid ? i_owner_id : '0;
        for (int i = 0; i < CORES; i++) begin
            w_core_bit[i]  = (i_core == CW'(i));
            w_owner_bit[i] = (w_oid == CW'(i));
        end
        w_owner_mask = w_ov ? w_owner_bit : '0;
    end

    always_comb begin
        o_valid    = i_valid;
        o_owner_id = w_oid;
        o_probe    = '0;
        w_nov      = w_ov;
        w_nd       = w_d;
        w_nsh      = w_sh;
        case (i_op)
            OP_ACQ_S: begin
                o_valid = 1'b1;
                if (w_ov && (w_oid != i_core)) begin
                    o_probe = w_owner_mask;
                    w_nsh   = w_owner_mask | w_core_bit;
                    w_nov   = 1'b0;
                    w_nd    = 1'b0;
                end else if (!w_ov) begin
                    w_nsh = w_sh | w_core_bit;
                end
                // A core that already owns the line keeps exclusive ownership unchanged.
            end
            OP_ACQ_E: begin
                o_probe    = (w_sh | w_owner_mask) & ~w_core_bit;
                o_valid    = 1'b1;
                o_owner_id = i_core;
                w_nsh      = '0;
                w_nov      = 1'b1;
                w_nd       = 1'b0;
            end
            OP_RELEASE: begin
                w_nsh = w_sh & ~w_core_bit;
                if (w_ov && (w_oid == i_core)) begin
                    w_nov = 1'b0;
                    w_nd  = 1'b0;
                end
            end
            OP_EVICT: begin
                o_probe    = w_sh | w_owner_mask;
                o_valid    = 1'b0;
                o_owner_id = '0;
                w_nsh      = '0;
                w_nov      = 1'b0;
                w_nd       = 1'b0;
            end
            default: ;
        endcase
        // Owned lines carry no sharers and only owned lines may be dirty.
        o_owner_valid = w_nov;
        o_dirty       = w_nd & w_nov;
        o_sharers     = w_nov ? '0 : w_nsh;
    end

endmodule

// File: rtl/rv64g_l2_dir_update.sv
// L2 directory update controller: read entry, write updated entry, return probe mask.
// Optional counters stat_req_o / stat_probe_o exist only when RV64G_L2_DIR_UPDATE_STATS_EN is defined.
module rv64g_l2_dir_update
    import rv64g_l2_pkg::*;
#(
    parameter  int SETS  = 256,
    parameter  int WAYS  = 16,
    parameter  int CORES = 4,
    localparam int SW    = (SETS  > 1) ? $clog2(SETS)  : 1,
    localparam int WW    = (WAYS  > 1) ? $clog2(WAYS)  : 1,
    localparam int CW    = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [SW-1:0]         req_set_i,
    input  logic [WW-1:0]         req_way_i,
    input  logic [CW-1:0]         req_core_i,
    output logic [SW-1:0]         rd_set_o,
    input  logic [WAYS-1:0]       rd_valid_i,
    input  logic [WAYS-1:0]       rd_owner_valid_i,
    input  logic [WAYS-1:0]       rd_dirty_i,
    input  logic [WAYS*CORES-1:0] rd_sharers_i,
    input  logic [WAYS*CW-1:0]    rd_owner_id_i,
    output logic                  we_o,
    output logic [SW-1:0]         wr_set_o,
    output logic [WW-1:0]         wr_way_o,
    output logic                  wr_valid_o,
    output logic                  wr_owner_valid_o,
    output logic                  wr_dirty_o,
    output logic [CORES-1:0]      wr_sharers_o,
    output logic [CW-1:0]         wr_owner_id_o,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [CORES-1:0]      resp_probe_o
`ifdef RV64G_L2_DIR_UPDATE_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_req_o,
    output logic [STAT_W-1:0]     stat_probe_o
`endif
);

    dir_state_e       r_state;
    dir_op_e          r_op;
    logic [SW-1:0]    r_set;
    logic [WW-1:0]    r_way;
    logic [CW-1:0]    r_core;
    logic [CORES-1:0] r_probe;

    logic             r_ready;
    logic             r_we;
    logic [SW-1:0]    r_wr_set;
    logic [WW-1:0]    r_wr_way;
    logic             r_wr_valid;
    logic             r_wr_owner_valid;
    logic             r_wr_dirty;
    logic [CORES-1:0] r_wr_sharers;
    logic [CW-1:0]    r_wr_owner_id;
    logic             r_resp_valid;
    logic [CORES-1:0] r_resp_probe;

    logic             w_sel_valid;
    logic             w_sel_owner_valid;
    logic             w_sel_dirty;
    logic [CORES-1:0] w_sel_sharers;
    logic [CW-1:0]    w_sel_owner_id;

    logic             w_nxt_valid;
    logic             w_nxt_owner_valid;
    logic             w_nxt_dirty;
    logic [CORES-1:0] w_nxt_sharers;
    logic [CW-1:0]    w_nxt_owner_id;
    logic [CORES-1:0] w_nxt_probe;

    // Directory read data is combinational on rd_set_o, so the way mux is valid throughout READ.
    always_comb begin
        w_sel_valid       = rd_valid_i[r_way];
        w_sel_owner_valid = rd_owner_valid_i[r_way];
        w_sel_dirty       = rd_dirty_i[r_way];
        w_sel_sharers     = rd_sharers_i[r_way*CORES +: CORES];
        w_sel_owner_id    = rd_owner_id_i[r_way*CW +: CW];
    end

    rv64g_l2_dir_next #(
        .CORES (CORES)
    ) u_next (
        .i_op          (r_op),
        .i_core        (r_core),
        .i_valid       (w_sel_valid),
        .i_owner_valid (w_sel_owner_valid),
        .i_dirty       (w_sel_dirty),
        .i_sharers     (w_sel_sharers),
        .i_owner_id    (w_sel_owner_id),
        .o_valid       (w_nxt_valid),
        .o_owner_valid (w_nxt_owner_valid),
        .o_dirty       (w_nxt_dirty),
        .o_sharers     (w_nxt_sharers),
        .o_owner_id    (w_nxt_owner_id),
        .o_probe       (w_nxt_probe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_op             <= OP_ACQ_S;
            r_set            <= '0;
            r_way            <= '0;
            r_core           <= '0;
            r_probe          <= '0;
            r_ready          <= 1'b1;
            r_we             <= 1'b0;
            r_wr_set         <= '0;
            r_wr_way         <= '0;
            r_wr_valid       <= 1'b0;
            r_wr_owner_valid <= 1'b0;
            r_wr_dirty       <= 1'b0;
            r_wr_sharers     <= '0;
            r_wr_owner_id    <= '0;
            r_resp_valid     <= 1'b0;
            r_resp_probe     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i && r_ready) begin
                        r_op    <= dir_op_e'(req_op_i);
                        r_set   <= req_set_i;
                        r_way   <= req_way_i;
                        r_core  <= req_core_i;
                        r_ready <= 1'b0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_we             <= 1'b1;
                    r_wr_set         <= r_set;
                    r_wr_way         <= r_way;
                    r_wr_valid       <= w_nxt_valid;
                    r_wr_owner_valid <= w_nxt_owner_valid;
                    r_wr_dirty       <= w_nxt_dirty;
                    r_wr_sharers     <= w_nxt_sharers;
                    r_wr_owner_id    <= w_nxt_owner_id;
                    r_probe          <= w_nxt_probe;
                    r_state          <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_we             <= 1'b0;
                    r_wr_set         <= '0;
                    r_wr_way         <= '0;
                    r_wr_valid       <= 1'b0;
                    r_wr_owner_valid <= 1'b0;
                    r_wr_dirty       <= 1'b0;
                    r_wr_sharers     <= '0;
                    r_wr_owner_id    <= '0;
                    r_resp_valid     <= 1'b1;
                    r_resp_probe     <= r_probe;
                    r_state          <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_resp_probe <= '0;
                        r_ready      <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o      = r_ready;
    assign rd_set_o         = r_set;
    assign we_o             = r_we;
    assign wr_set_o         = r_wr_set;
    assign wr_way_o         = r_wr_way;
    assign wr_valid_o       = r_wr_valid;
    assign wr_owner_valid_o = r_wr_owner_valid;
    assign wr_dirty_o       = r_wr_dirty;
    assign wr_sharers_o     = r_wr_sharers;
    assign wr_owner_id_o    = r_wr_owner_id;
    assign resp_valid_o     = r_resp_valid;
    assign resp_probe_o     = r_resp_probe;

`ifdef RV64G_L2_DIR_UPDATE_STATS_EN
    function automatic logic [STAT_W-1:0] popcount(input logic [CORES-1:0] v);
        logic [STAT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CORES; i++) begin
            n = n + STAT_W'(v[i]);
        end
        return n;
    endfunction

    logic [STAT_W-1:0] r_stat_req;
    logic [STAT_W-1:0] r_stat_probe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_req   <= '0;
            r_stat_probe <= '0;
        end else begin
            if (req_valid_i && r_ready && (r_state == ST_IDLE)) begin
                r_stat_req <= r_stat_req + 1'b1;
            end
            if (r_resp_valid && resp_ready_i) begin
                r_stat_probe <= r_stat_probe + popcount(r_resp_probe);
            end
        end
    end

    assign stat_req_o   = r_stat_req;
    assign stat_probe_o = r_stat_probe;
`endif

endmodule

// File: tb/tb_rv64g_l2_dir_update.sv
// Bench for rv64g_l2_dir_update: directory RAM model, directed coherence cases, randomized traffic.
// Optional counters are checked when RV64G_L2_DIR_UPDATE_STATS_EN is defined.
module tb_rv64g_l2_dir_update;

    localparam int SETS  = 256;
    localparam int WAYS  = 16;
    localparam int CORES = 4;
    localparam int SW    = 8;
    localparam int WW    = 4;
    localparam int CW    = 2;

    typedef struct {
        bit v;
        bit ov;
        bit d;
        int sh;
        int oid;
    } entry_t;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [SW-1:0]         req_set;
    logic [WW-1:0]         req_way;
    logic [CW-1:0]         req_core;
    logic [SW-1:0]         rd_set;
    logic [WAYS-1:0]       rd_valid;
    logic [WAYS-1:0]       rd_owner_valid;
    logic [WAYS-1:0]       rd_dirty;
    logic [WAYS*CORES-1:0] rd_sharers;
    logic [WAYS*CW-1:0]    rd_owner_id;
    logic                  we;
    logic [SW-1:0]         wr_set;
    logic [WW-1:0]         wr_way;
    logic                  wr_valid;
    logic                  wr_ov;
    logic                  wr_dirty;
    logic [CORES-1:0]      wr_sharers;
    logic [CW-1:0]         wr_oid;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [CORES-1:0]      resp_probe;
`ifdef RV64G_L2_DIR_UPDATE_STATS_EN
    logic [31:0]           stat_req;
    logic [31:0]           stat_probe;
`endif

    entry_t mem [SETS][WAYS];
    int     n_checks;
    int     n_fail;
    int     cyc;
    int     last_probe;
    int     exp_req;
    int     exp_probe_sum;

    rv64g_l2_dir_update #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .CORES (CORES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_i         (req_op),
        .req_set_i        (req_set),
        .req_way_i        (req_way),
        .req_core_i       (req_core),
        .rd_set_o         (rd_set),
        .rd_valid_i       (rd_valid),
        .rd_owner_valid_i (rd_owner_valid),
        .rd_dirty_i       (rd_dirty),
        .rd_sharers_i     (rd_sharers),
        .rd_owner_id_i    (rd_owner_id),
        .we_o             (we),
        .wr_set_o         (wr_set),
        .wr_way_o         (wr_way),
        .wr_valid_o       (wr_valid),
        .wr_owner_valid_o (wr_ov),
        .wr_dirty_o       (wr_dirty),
        .wr_sharers_o     (wr_sharers),
        .wr_owner_id_o    (wr_oid),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .resp_probe_o     (resp_probe)
`ifdef RV64G_L2_DIR_UPDATE_STATS_EN
        ,
        .stat_req_o       (stat_req),
        .stat_probe_o     (stat_probe)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational directory RAM read port.
    always_comb begin
        rd_valid       = '0;
        rd_owner_valid = '0;
        rd_dirty       = '0;
        rd_sharers     = '0;
        rd_owner_id    = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_valid[w]                  = mem[rd_set][w].v;
            rd_owner_valid[w]            = mem[rd_set][w].ov;
            rd_dirty[w]                  = mem[rd_set][w].d;
            rd_sharers[w*CORES +: CORES] = 4'(mem[rd_set][w].sh);
            rd_owner_id[w*CW +: CW]      = 2'(mem[rd_set][w].oid);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Coherence rules applied to a whole entry with integer bitmasks.
    function automatic void ref_model(input int op, input int core, input entry_t cur,
                                      output entry_t nxt, output int probe);
        entry_t e;
        int cb;
        int ob;
        e = cur;
        if (!e.v) e = '{v: 0, ov: 0, d: 0, sh: 0, oid: 0};
        cb    = 1 << core;
        ob    = e.ov ? (1 << e.oid) : 0;
        nxt   = e;
        probe = 0;
        case (op)
            0: begin
                if (e.ov && e.oid != core) begin
                    probe  = ob;
                    nxt.sh = ob | cb;
                    nxt.ov = 0;
                    nxt.d  = 0;
                end else if (!e.ov) begin
                    nxt.sh = e.sh | cb;
                end
                nxt.v = 1;
            end
            1: begin
                probe   = (e.sh | ob) & ~cb;
                nxt.sh  = 0;
                nxt.ov  = 1;
                nxt.oid = core;
                nxt.d   = 0;
                nxt.v   = 1;
            end
            2: begin
                nxt.sh = e.sh & ~cb;
                if (e.ov && e.oid == core) begin
                    nxt.ov = 0;
                    nxt.d  = 0;
                end
            end
            default: begin
                probe = e.sh | ob;
                nxt   = '{v: 0, ov: 0, d: 0, sh: 0, oid: 0};
            end
        endcase
        probe = probe & 15;
    endfunction

    function automatic logic [6:0] state_bits(input entry_t e);
        return {e.v, e.ov, e.d, 4'(e.sh)};
    endfunction

    task automatic run_req(input int op, input int set, input int way, input int core, input int stall);
        entry_t     exp_e;
        int         exp_p;
        int         acc;
        int         lat;
        int         nwr;
        logic [8:0] exp_w;
        ref_model(op, core, mem[set][way], exp_e, exp_p);
        exp_w = {exp_e.v, exp_e.ov, exp_e.d, 4'(exp_e.sh), 2'(exp_e.oid)};
        check_eq("ready_idle", 64'(req_ready), 64'(1));
        req_valid  = 1'b1;
        req_op     = 2'(op);
        req_set    = 8'(set);
        req_way    = 4'(way);
        req_core   = 2'(core);
        resp_ready = 1'b0;
        acc        = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        exp_req++;
        check_eq("rd_set", {rd_set, we, resp_valid}, {8'(set), 1'b0, 1'b0});
        lat = -1;
        nwr = 0;
        for (int k = 0; k < 8 && lat < 0; k++) begin
            @(negedge clk);
            if (we) begin
                nwr++;
                check_eq("wr_addr", {wr_set, wr_way}, {8'(set), 4'(way)});
                check_eq("wr_entry", {wr_valid, wr_ov, wr_dirty, wr_sharers, wr_oid}, exp_w);
                check_eq("probe_in_write", 64'(resp_probe), 64'(0));
                mem[set][way] = '{v: wr_valid, ov: wr_ov, d: wr_dirty,
                                  sh: int'(wr_sharers), oid: int'(wr_oid)};
            end
            if (resp_valid) lat = cyc - acc;
        end
        check_eq("latency", 64'(lat), 64'(3));
        check_eq("we_count", 64'(nwr), 64'(1));
        check_eq("probe", 64'(resp_probe), 64'(exp_p));
        last_probe = int'(resp_probe);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("hold", {resp_valid, req_ready, we, resp_probe}, {1'b1, 1'b0, 1'b0, 4'(exp_p)});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        exp_probe_sum += $countones(4'(exp_p));
        check_eq("after_resp", {resp_valid, req_ready, we, resp_probe, wr_valid, wr_sharers},
                 {1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 4'b0});
    endtask

    task automatic reset_mid_write();
        entry_t saved;
        bit     seen;
        mem[50][0] = '{v: 1, ov: 0, d: 0, sh: 3, oid: 0};
        saved      = mem[50][0];
        req_valid  = 1'b1;
        req_op     = 2'd1;
        req_set    = 8'd50;
        req_way    = 4'd0;
        req_core   = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (we) seen = 1;
        end
        check_eq("rst_write_seen", 64'(seen), 64'(1));
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", {we, resp_valid, rd_set, resp_probe}, {1'b0, 1'b0, 8'h0, 4'h0});
        @(negedge clk);
        rst_n = 1'b1;
        exp_req       = 0;
        exp_probe_sum = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("post_rst", {we, resp_valid, req_ready}, {1'b0, 1'b0, 1'b1});
        end
        check_eq("rst_no_write", 64'(state_bits(mem[50][0])), 64'(state_bits(saved)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        exp_req       = 0;
        exp_probe_sum = 0;
        last_probe    = 0;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_op        = '0;
        req_set       = '0;
        req_way       = '0;
        req_core      = '0;
        resp_ready    = 1'b0;

        // Random but coherent entries in sets 0..7; invalid entries carry garbage fields.
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                mem[s][w].v   = 1'($urandom_range(0, 1));
                mem[s][w].oid = int'($urandom_range(0, 3));
                if (mem[s][w].v) begin
                    mem[s][w].ov = 1'($urandom_range(0, 1));
                    mem[s][w].sh = mem[s][w].ov ? 0 : int'($urandom_range(0, 15));
                    mem[s][w].d  = mem[s][w].ov ? 1'($urandom_range(0, 1)) : 1'b0;
                end else begin
                    mem[s][w].ov = 1'($urandom_range(0, 1));
                    mem[s][w].sh = int'($urandom_range(0, 15));
                    mem[s][w].d  = 1'($urandom_range(0, 1));
                end
            end
        end

        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {we, resp_valid, rd_set, resp_probe, wr_set, wr_way, wr_valid, wr_sharers},
                 {1'b0, 1'b0, 8'h0, 4'h0, 8'h0, 4'h0, 1'b0, 4'h0});
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_ready", 64'(req_ready), 64'(1));

        mem[10][5] = '{v: 0, ov: 0, d: 0, sh: 0, oid: 0};
        run_req(0, 10, 5, 1, 0);
        check_eq("acqs_empty_entry", 64'(state_bits(mem[10][5])), 64'(7'b1_0_0_0010));
        check_eq("acqs_empty_probe", 64'(last_probe), 64'(0));

        mem[20][3] = '{v: 1, ov: 0, d: 0, sh: 4'b1010, oid: 0};
        run_req(1, 20, 3, 2, 1);
        check_eq("acqe_probe", 64'(last_probe), 64'(4'b1010));
        check_eq("acqe_entry", {state_bits(mem[20][3]), 2'(mem[20][3].oid)}, {7'b1_1_0_0000, 2'd2});

        mem[30][7] = '{v: 1, ov: 1, d: 1, sh: 0, oid: 3};
        run_req(0, 30, 7, 0, 2);
        check_eq("acqs_demote_probe", 64'(last_probe), 64'(4'b1000));
        check_eq("acqs_demote_entry", 64'(state_bits(mem[30][7])), 64'(7'b1_0_0_1001));

        mem[40][1] = '{v: 1, ov: 1, d: 0, sh: 0, oid: 2};
        run_req(3, 40, 1, 0, 0);
        check_eq("evict_probe", 64'(last_probe), 64'(4'b0100));
        check_eq("evict_entry", {state_bits(mem[40][1]), 2'(mem[40][1].oid)}, 9'b0);

        mem[40][2] = '{v: 1, ov: 0, d: 0, sh: 4'b0011, oid: 0};
        run_req(2, 40, 2, 1, 0);
        check_eq("release_probe", 64'(last_probe), 64'(0));
        check_eq("release_entry", 64'(state_bits(mem[40][2])), 64'(7'b1_0_0_0001));

        mem[60][9] = '{v: 1, ov: 0, d: 0, sh: 4'b0110, oid: 0};
        run_req(1, 60, 9, 0, 5);
        check_eq("stall_probe", 64'(last_probe), 64'(4'b0110));

        reset_mid_write();

        for (int i = 0; i < 200; i++) begin
            run_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        end

`ifdef RV64G_L2_DIR_UPDATE_STATS_EN
        check_eq("stat_req", 64'(stat_req), 64'(exp_req));
        check_eq("stat_probe", 64'(stat_probe), 64'(exp_probe_sum));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
